// File: rtl/add_sub_pipe_pkg.sv
// Shared definitions for the pipelined add/subtract unit.
//   OP_*            operation encoding carried on in_op
//   op_inverts_y    1 when the y operand enters the adder inverted (SUB/SBB)
//   op_carry_in     carry injected into the lowest slice for a given operation
package add_sub_pipe_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ADC = 2'b10;
    localparam logic [1:0] OP_SBB = 2'b11;

    function automatic logic op_inverts_y(input logic [1:0] op);
        return (op == OP_SUB) || (op == OP_SBB);
    endfunction

    // SUB is x + ~y + 1; ADC/SBB take the external carry (SBB: 1 = no borrow).
    function automatic logic op_carry_in(input logic [1:0] op, input logic cin);
        logic c;
        case (op)
            OP_ADD:  c = 1'b0;
            OP_SUB:  c = 1'b1;
            OP_ADC:  c = cin;
            default: c = cin;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/add_sub_slice.sv
// Combinational LANE-bit adder slice.
//   a, b    slice operands (b already inverted for subtraction)
//   cin     carry into the slice
//   s       slice sum
//   cout    carry out of the slice
//   a_msb, b_msb, s_msb   top bits of a, b and s, used for the overflow flag
module add_sub_slice
    import add_sub_pipe_pkg::*;
#(
    parameter int LANE = 8
) (
    input  logic [LANE-1:0] a,
    input  logic [LANE-1:0] b,
    input  logic            cin,
    output logic [LANE-1:0] s,
    output logic            cout,
    output logic            a_msb,
    output logic            b_msb,
    output logic            s_msb
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{LANE{1'b0}}, cin};
    assign a_msb     = a[LANE-1];
    assign b_msb     = b[LANE-1];
    assign s_msb     = s[LANE-1];

endmodule

// File: rtl/add_sub_pipe.sv
// Pipelined integer add/subtract unit with carry/overflow/zero/negative flags.
// The carry chain is cut into LANE-bit slices with one register stage per
// slice, so an operation takes STAGES = W/LANE cycles and one op can be
// accepted every cycle. A single global enable freezes the whole pipe when
// the consumer stalls the output.
//   clk, rst             clock and synchronous active-high reset
//   in_valid/in_ready    operand handshake
//   in_x, in_y, in_op    operands and operation (ADD/SUB/ADC/SBB)
//   in_cin               carry-in for ADC/SBB
//   out_valid/out_ready  result handshake
//   out_s                result
//   out_c, out_o         carry-out (1 = no borrow for SUB/SBB), signed overflow
//   out_z, out_n         result is zero, result sign bit
module add_sub_pipe
    import add_sub_pipe_pkg::*;
#(
    parameter int W    = 32,
    parameter int LANE = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_x,
    input  logic [W-1:0] in_y,
    input  logic [1:0]   in_op,
    input  logic         in_cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_s,
    output logic         out_c,
    output logic         out_o,
    output logic         out_z,
    output logic         out_n
);

    localparam int STAGES = W / LANE;

    // Signed overflow: operands agree in sign but the sum does not.
    function automatic logic signed_ovf(input logic x_msb, input logic y_msb,
                                        input logic s_msb);
        return ~(x_msb ^ y_msb) & (s_msb ^ x_msb);
    endfunction

    logic         stall;
    logic         en;
    logic [W-1:0] yp_in;
    logic         cin_in;

    assign stall    = out_valid & ~out_ready;
    assign en       = ~stall;
    assign in_ready = en;
    assign yp_in    = op_inverts_y(in_op) ? ~in_y : in_y;
    assign cin_in   = op_carry_in(in_op, in_cin);

    // Stage k resolves bits [k*LANE +: LANE]. Operand registers shrink as the
    // pipe advances (only bits not yet added travel on); the finished low
    // result bits grow by one lane per stage.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [W-k*LANE-1:0]   x_hi;
        logic [W-k*LANE-1:0]   yp_hi;
        logic                  c_src;
        logic                  v_src;
        logic [LANE-1:0]       sum;
        logic                  cout;
        logic                  x_msb;
        logic                  yp_msb;
        logic                  s_msb;
        logic [(k+1)*LANE-1:0] s_acc;

        if (k == 0) begin : g_src
            assign x_hi  = in_x;
            assign yp_hi = yp_in;
            assign c_src = cin_in;
            assign v_src = in_valid;
            assign s_acc = sum;
        end else begin : g_src
            assign x_hi  = g_stage[k-1].g_reg.x_p;
            assign yp_hi = g_stage[k-1].g_reg.yp_p;
            assign c_src = g_stage[k-1].g_reg.c_p;
            assign v_src = g_stage[k-1].g_reg.vld_p;
            assign s_acc = {sum, g_stage[k-1].g_reg.s_p};
        end

        add_sub_slice #(.LANE(LANE)) u_slice (
            .a     (x_hi[LANE-1:0]),
            .b     (yp_hi[LANE-1:0]),
            .cin   (c_src),
            .s     (sum),
            .cout  (cout),
            .a_msb (x_msb),
            .b_msb (yp_msb),
            .s_msb (s_msb)
        );

        if (k < STAGES - 1) begin : g_reg
            logic [W-(k+1)*LANE-1:0] x_p;
            logic [W-(k+1)*LANE-1:0] yp_p;
            logic [(k+1)*LANE-1:0]   s_p;
            logic                    c_p;
            logic                    vld_p;
            // Sign taps only matter in the top slice.
            logic                    unused_msbs;

            assign unused_msbs = x_msb ^ yp_msb ^ s_msb;

            // ---- stage k -> k+1 register boundary ----
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_p <= 1'b0;
                    x_p   <= '0;
                    yp_p  <= '0;
                    s_p   <= '0;
                    c_p   <= 1'b0;
                end else if (en) begin
                    vld_p <= v_src;
                    if (v_src) begin
                        x_p  <= x_hi[W-k*LANE-1:LANE];
                        yp_p <= yp_hi[W-k*LANE-1:LANE];
                        s_p  <= s_acc;
                        c_p  <= cout;
                    end
                end
            end
        end else begin : g_out
            logic [W-1:0] s_p;
            logic         c_p;
            logic         o_p;
            logic         z_p;
            logic         n_p;
            logic         vld_p;

            // ---- final stage: result and flag registers ----
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_p <= 1'b0;
                    s_p   <= '0;
                    c_p   <= 1'b0;
                    o_p   <= 1'b0;
                    z_p   <= 1'b0;
                    n_p   <= 1'b0;
                end else if (en) begin
                    vld_p <= v_src;
                    if (v_src) begin
                        s_p <= s_acc;
                        c_p <= cout;
                        o_p <= signed_ovf(x_msb, yp_msb, s_msb);
                        z_p <= ~|s_acc;
                        n_p <= s_msb;
                    end
                end
            end

            assign out_valid = vld_p;
            assign out_s     = s_p;
            assign out_c     = c_p;
            assign out_o     = o_p;
            assign out_z     = z_p;
            assign out_n     = n_p;
        end
    end

endmodule
